twofish_seq_ctrl: RTL
=====================

// Module: twofish_seq_ctrl
// PURPOSE
//  Sequences the Twofish cipher core on behalf of the NIOS PIO bank: detects a software start edge,
//  latches key/block/direction/tag, runs key schedule only when the key changed, issues one block
//  operation, captures the result and reports status. Sits between the PIO exports and the core;
//  adds key caching, overrun detection, a busy watchdog and core recovery reset.
// PARAMETERS
//  TIMEOUT_CYCLES   4096  max cycles any core busy phase may last before error/recovery
//  CORE_RST_CYCLES  4     length of core_rst pulse on timeout or host abort
// PORTS
//  clk              in   1    system clock (sole clock)
//  reset            in   1    synchronous, active-high reset
//  host_key0..3     in   32   key words (key0 = bits 127:96 of core_key)
//  host_block0..3   in   32   input block words (block0 = bits 127:96)
//  host_ende        in   1    1 = encrypt, 0 = decrypt
//  host_start       in   1    software-written level; rising edge requests an operation
//  host_abort       in   1    level; 1 = abort and reset core
//  host_addr        in   8    request tag, echoed in status
//  host_out0..3     out  32   last captured result words
//  host_busy        out  1    1 while a request is in progress
//  host_status      out  32   {16'b0, tag[7:0], 2'b0, key_valid, timeout_err, overrun, done, 2'b0}
//  core_key         out  128  key to core        core_key_load out 1  1-cycle key-schedule pulse
//  core_din         out  128  block to core      core_start    out 1  1-cycle block pulse
//  core_ende        out  1    direction to core  core_rst      out 1  core reset (active-high)
//  core_busy        in   1    core busy (key schedule or block)
//  core_dout        in   128  core result, valid when core_busy falls
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, key_valid=0, start_q=0, all flags/counters 0.
//  - Start edge = host_start & ~start_q (start_q registered every cycle); held level never retriggers.
//  - States: IDLE, KEY_LOAD, KEY_WAIT, BLK_START, BLK_WAIT, RECOVER.
//  - IDLE + edge (cycle N): latch key, block, ende, tag; clear done, overrun, timeout_err;
//    host_busy=1 from N+1. Next: KEY_LOAD if !key_valid or key != cached key, else BLK_START.
//  - KEY_LOAD: core_key_load=1 this cycle only; cached key updated -> KEY_WAIT.
//  - KEY_WAIT / BLK_WAIT: first cycle ignores core_busy (core latency); afterwards leave when
//    core_busy==0. KEY_WAIT -> BLK_START with key_valid=1.
//  - BLK_START: core_start=1 this cycle only -> BLK_WAIT.
//  - BLK_WAIT exit cycle: host_out0..3 <= core_dout, done=1, host_busy=0, -> IDLE.
//  - Cached-key latency: edge at N -> core_start at N+1 -> done visible at M+1 where M is first
//    cycle (>= N+3) with core_busy==0.
//  - core_key/core_din/core_ende driven from latched regs; stable from N+1 until next accept.
//  - Edge while not IDLE: ignored, overrun=1 (sticky until next accepted start).
//  - Watchdog: counter clears on entry to each WAIT state, increments each WAIT cycle; reaching
//    TIMEOUT_CYCLES -> RECOVER with timeout_err=1.
//  - host_abort=1 in any state -> RECOVER (same cycle priority over all transitions); no done.
//  - RECOVER: core_rst=1 for CORE_RST_CYCLES cycles, key_valid=0, host_busy=1, then IDLE.
//    Edges during RECOVER set overrun; abort held high keeps restarting the RECOVER count.
//  - Edge and abort in same IDLE cycle: abort wins, request dropped, overrun=0.
//  - host_out retains previous result on abort/timeout; done stays 0.
//  - Watchdog width = $clog2(TIMEOUT_CYCLES+1); no wrap (saturates into RECOVER).
// STRUCTURE
//  - twofish_pkg: state enum, STATUS_* bit-index localparams, WORD_W=32, BLK_W=128.
//  - Sub-module twofish_watchdog (clear, enable, expired) for the timeout counter; rest flat.
// TESTING (core = behavioural model, key schedule 20 cycles, block 16 cycles)
//  1 key=0, block=0, ende=1, start 0->1 -> one core_key_load, one core_start; out =
//    9F589F5C_F6122C32_B6BFEC2F_2AE8C35A, done=1, key_valid=1, tag echoed.
//  2 repeat same key, new block -> no core_key_load; core_start exactly 1 cycle after edge.
//  3 edge again 5 cycles into BLK_WAIT -> overrun=1, result unaffected; next accept clears it.
//  4 model holds core_busy forever, TIMEOUT_CYCLES=64 -> RECOVER at wait cycle 64, core_rst 4
//    cycles, timeout_err=1, key_valid=0, next request reloads key.
//  5 host_abort during KEY_WAIT -> RECOVER, host_out unchanged, done=0; host_start held high
//    throughout never retriggers until toggled low then high.
//  6 reset asserted mid BLK_WAIT -> next cycle all outputs 0, state IDLE.

Source files
------------

// File: rtl/twofish_pkg.sv
// ---------------------------------------------------------------------------
// twofish_pkg
//   Shared constants for the Twofish sequencing controller: data widths,
//   controller state encodings and host_status bit positions.
// ---------------------------------------------------------------------------
package twofish_pkg;

    localparam int WORD_W = 32;
    localparam int BLK_W  = 128;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_KEY_LOAD  = 3'd1;
    localparam state_t ST_KEY_WAIT  = 3'd2;
    localparam state_t ST_BLK_START = 3'd3;
    localparam state_t ST_BLK_WAIT  = 3'd4;
    localparam state_t ST_RECOVER   = 3'd5;

    // host_status bit positions
    localparam int STATUS_DONE      = 2;
    localparam int STATUS_OVERRUN   = 3;
    localparam int STATUS_TIMEOUT   = 4;
    localparam int STATUS_KEY_VALID = 5;
    localparam int STATUS_TAG_LSB   = 8;

endpackage

// File: rtl/twofish_watchdog.sv
// ---------------------------------------------------------------------------
// twofish_watchdog
//   Saturating busy-phase timer for the sequencing controller.
//   Ports:
//     clk, reset  - system clock, synchronous active-high reset
//     i_clear     - zero the counter (asserted on the cycle before a wait phase)
//     i_enable    - count this cycle (asserted in every wait-phase cycle)
//     o_expired   - this enabled cycle brings the count to TIMEOUT_CYCLES
// ---------------------------------------------------------------------------
module twofish_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Fires in the wait cycle whose increment reaches the limit.
    assign o_expired = i_enable && (r_cnt >= (LIMIT - 1'b1));

endmodule

// File: rtl/twofish_seq_ctrl.sv
// ---------------------------------------------------------------------------
// twofish_seq_ctrl
//   Sequences a Twofish core for a PIO-driven host: start-edge detect, request
//   latching, key schedule only on key change, one block operation, result
//   capture, overrun detection, busy watchdog and core recovery reset.
//   Ports:
//     clk, reset               - system clock, synchronous active-high reset
//     host_key0..3             - key words (key0 = core_key[127:96])
//     host_block0..3           - input block words (block0 = core_din[127:96])
//     host_ende                - 1 encrypt, 0 decrypt
//     host_start               - level; rising edge requests an operation
//     host_abort               - level; forces core recovery
//     host_addr                - request tag echoed in host_status
//     host_out0..3             - last captured result
//     host_busy                - request or recovery in progress
//     host_status              - {16'b0, tag, 2'b0, key_valid, timeout, overrun, done, 2'b0}
//     core_key/din/ende        - latched request towards the core
//     core_key_load/core_start - single-cycle core command pulses
//     core_rst                 - core reset during recovery
//     core_busy, core_dout     - core handshake and result
// ---------------------------------------------------------------------------
module twofish_seq_ctrl
    import twofish_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES  = 4096,
    parameter int unsigned CORE_RST_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] host_key0,
    input  logic [WORD_W-1:0] host_key1,
    input  logic [WORD_W-1:0] host_key2,
    input  logic [WORD_W-1:0] host_key3,
    input  logic [WORD_W-1:0] host_block0,
    input  logic [WORD_W-1:0] host_block1,
    input  logic [WORD_W-1:0] host_block2,
    input  logic [WORD_W-1:0] host_block3,
    input  logic              host_ende,
    input  logic              host_start,
    input  logic              host_abort,
    input  logic [7:0]        host_addr,
    output logic [WORD_W-1:0] host_out0,
    output logic [WORD_W-1:0] host_out1,
    output logic [WORD_W-1:0] host_out2,
    output logic [WORD_W-1:0] host_out3,
    output logic              host_busy,
    output logic [31:0]       host_status,
    output logic [BLK_W-1:0]  core_key,
    output logic              core_key_load,
    output logic [BLK_W-1:0]  core_din,
    output logic              core_start,
    output logic              core_ende,
    output logic              core_rst,
    input  logic              core_busy,
    input  logic [BLK_W-1:0]  core_dout
);

    localparam int unsigned RST_W = $clog2(CORE_RST_CYCLES + 1);
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(CORE_RST_CYCLES - 1);

    state_t             r_state;
    state_t             w_state_d;
    logic               r_start_q;
    logic [BLK_W-1:0]   r_key;
    logic [BLK_W-1:0]   r_key_cache;
    logic [BLK_W-1:0]   r_blk;
    logic               r_ende;
    logic [7:0]         r_tag;
    logic               r_key_valid;
    logic [BLK_W-1:0]   r_out;
    logic               r_done;
    logic               r_overrun;
    logic               r_timeout;
    logic               r_wait_first;
    logic [RST_W-1:0]   r_rst_cnt;

    logic               w_edge;
    logic               w_accept;
    logic [BLK_W-1:0]   w_key_in;
    logic               w_key_hit;
    logic               w_in_wait;
    logic               w_wait_done;
    logic               w_expired;
    logic               w_timeout;

    assign w_edge      = host_start & ~r_start_q;
    assign w_key_in    = {host_key0, host_key1, host_key2, host_key3};
    assign w_key_hit   = r_key_valid && (w_key_in == r_key_cache);
    assign w_in_wait   = (r_state == ST_KEY_WAIT) || (r_state == ST_BLK_WAIT);
    // First wait cycle ignores core_busy: the core has not yet raised it.
    assign w_wait_done = w_in_wait && !r_wait_first && !core_busy;
    assign w_timeout   = w_expired && !w_wait_done && !host_abort;
    assign w_accept    = (r_state == ST_IDLE) && w_edge && !host_abort;

    twofish_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .i_clear  ((r_state == ST_KEY_LOAD) || (r_state == ST_BLK_START)),
        .i_enable (w_in_wait),
        .o_expired(w_expired)
    );

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_edge) w_state_d = w_key_hit ? ST_BLK_START : ST_KEY_LOAD;
            end
            ST_KEY_LOAD:  w_state_d = ST_KEY_WAIT;
            ST_KEY_WAIT: begin
                if (w_wait_done)    w_state_d = ST_BLK_START;
                else if (w_expired) w_state_d = ST_RECOVER;
            end
            ST_BLK_START: w_state_d = ST_BLK_WAIT;
            ST_BLK_WAIT: begin
                if (w_wait_done)    w_state_d = ST_IDLE;
                else if (w_expired) w_state_d = ST_RECOVER;
            end
            ST_RECOVER: begin
                if (r_rst_cnt == RST_LAST) w_state_d = ST_IDLE;
            end
            default: w_state_d = ST_IDLE;
        endcase
        // Abort overrides every transition, including a same-cycle start.
        if (host_abort) w_state_d = ST_RECOVER;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_start_q    <= 1'b0;
            r_key        <= '0;
            r_key_cache  <= '0;
            r_blk        <= '0;
            r_ende       <= 1'b0;
            r_tag        <= '0;
            r_key_valid  <= 1'b0;
            r_out        <= '0;
            r_done       <= 1'b0;
            r_overrun    <= 1'b0;
            r_timeout    <= 1'b0;
            r_wait_first <= 1'b0;
            r_rst_cnt    <= '0;
        end else begin
            r_state      <= w_state_d;
            r_start_q    <= host_start;
            r_wait_first <= (r_state == ST_KEY_LOAD) || (r_state == ST_BLK_START);

            if (w_accept) begin
                r_key     <= w_key_in;
                r_blk     <= {host_block0, host_block1, host_block2, host_block3};
                r_ende    <= host_ende;
                r_tag     <= host_addr;
                r_done    <= 1'b0;
                r_overrun <= 1'b0;
                r_timeout <= 1'b0;
            end else if (w_edge && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end

            if (r_state == ST_KEY_LOAD) r_key_cache <= r_key;

            if (w_state_d == ST_RECOVER) begin
                r_key_valid <= 1'b0;
            end else if ((r_state == ST_KEY_WAIT) && w_wait_done) begin
                r_key_valid <= 1'b1;
            end

            if ((r_state == ST_BLK_WAIT) && (w_state_d == ST_IDLE)) begin
                r_out  <= core_dout;
                r_done <= 1'b1;
            end

            if (w_timeout) r_timeout <= 1'b1;

            // Restarts while abort is held, so recovery lasts past its release.
            if (host_abort || (r_state != ST_RECOVER)) r_rst_cnt <= '0;
            else                                      r_rst_cnt <= r_rst_cnt + 1'b1;
        end
    end

    assign host_out0     = r_out[127:96];
    assign host_out1     = r_out[95:64];
    assign host_out2     = r_out[63:32];
    assign host_out3     = r_out[31:0];
    assign host_busy     = (r_state != ST_IDLE);
    assign host_status   = {16'b0, r_tag, 2'b0, r_key_valid, r_timeout, r_overrun, r_done, 2'b0};
    assign core_key      = r_key;
    assign core_din      = r_blk;
    assign core_ende     = r_ende;
    assign core_key_load = (r_state == ST_KEY_LOAD);
    assign core_start    = (r_state == ST_BLK_START);
    assign core_rst      = (r_state == ST_RECOVER);

endmodule
